// File: rtl/boreal_mbox_pkg.sv
// Shared types, encodings and address helpers for the AI mailbox writer.
package boreal_mbox_pkg;

    localparam int unsigned MBOX_WORDS = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned DATA_W     = 32;

    localparam logic [7:0] MBOX_SLOT0_VALID = 8'h00;
    localparam logic [7:0] MBOX_SLOT1_VALID = 8'h04;
    localparam logic [7:0] MBOX_SLOT0_DATA  = 8'h40;
    localparam logic [7:0] MBOX_SLOT1_DATA  = 8'h80;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SLOT = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PAD       = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_COMMIT    = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        WAIT_SLOT = ST_WAIT_SLOT,
        DATA      = ST_DATA,
        PAD       = ST_PAD,
        DRAIN     = ST_DRAIN,
        COMMIT    = ST_COMMIT
    } mbox_state_e;

    // One MMIO write request: address plus write data.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mmio_wr_t;

    // Address of data word idx inside the given slot.
    function automatic logic [DATA_W-1:0] data_addr(input logic [DATA_W-1:0] base,
                                                    input logic slot,
                                                    input logic [IDX_W-1:0] idx);
        logic [7:0] off;
        off = slot ? MBOX_SLOT1_DATA : MBOX_SLOT0_DATA;
        return base + DATA_W'(off) + DATA_W'({idx, 2'b00});
    endfunction

    // Address of the valid/commit register of the given slot.
    function automatic logic [DATA_W-1:0] commit_addr(input logic [DATA_W-1:0] base,
                                                      input logic slot);
        logic [7:0] off;
        off = slot ? MBOX_SLOT1_VALID : MBOX_SLOT0_VALID;
        return base + DATA_W'(off);
    endfunction

endpackage

// File: rtl/boreal_mmio_wr_port.sv
// Registered single-outstanding MMIO write master: latches a request on start,
// holds sel/addr/wdata stable until ack, drops sel the cycle after ack.
module boreal_mmio_wr_port
    import boreal_mbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  mmio_wr_t          req,
    input  logic              ack,
    output logic              sel,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              done_c
);

    assign done_c = sel && ack;

    // Request register: new requests are ignored while one is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else if (sel) begin
            if (ack) begin
                sel <= 1'b0;
            end
        end else if (start) begin
            sel   <= 1'b1;
            addr  <= req.addr;
            wdata <= req.data;
        end
    end

endmodule

// File: rtl/boreal_ai_mbox_writer.sv
// Producer-side sequencer: copies 16-word accelerator result bursts into
// ping-pong mailbox slots over MMIO and commits each slot with a valid write.
module boreal_ai_mbox_writer
    import boreal_mbox_pkg::*;
#(
    parameter logic [31:0] MB_BASE = 32'h0000_0000,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               res_valid,
    input  logic [31:0]        res_data,
    input  logic               res_last,
    output logic               res_ready,
    output logic               mb_sel,
    output logic               mb_wr,
    output logic [31:0]        mb_addr,
    output logic [31:0]        mb_wdata,
    input  logic               mb_ack,
    input  logic               slot0_valid,
    input  logic               slot1_valid,
    output logic               cur_slot,
    output logic               busy,
    output logic               overrun,
    output logic [STALL_W-1:0] stall_cnt,
    output logic [15:0]        commit_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MBOX_WORDS - 1);

    mbox_state_e      state;
    logic [IDX_W-1:0] idx;
    logic             last_q;
    logic             hs_c;
    logic             done_c;
    logic             start_c;
    logic             slot_busy_c;
    mmio_wr_t         req_c;

    assign mb_wr       = mb_sel;
    assign hs_c        = res_valid && res_ready;
    assign slot_busy_c = cur_slot ? slot1_valid : slot0_valid;

    boreal_mmio_wr_port u_port (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .req    (req_c),
        .ack    (mb_ack),
        .sel    (mb_sel),
        .addr   (mb_addr),
        .wdata  (mb_wdata),
        .done_c (done_c)
    );

    // Write request selection: data word on handshake, zero pad, or commit.
    always_comb begin
        start_c = 1'b0;
        req_c   = '0;
        unique case (state)
            DATA: begin
                start_c    = hs_c;
                req_c.addr = data_addr(MB_BASE, cur_slot, idx);
                req_c.data = res_data;
            end
            PAD: begin
                start_c    = !mb_sel;
                req_c.addr = data_addr(MB_BASE, cur_slot, idx);
                req_c.data = '0;
            end
            COMMIT: begin
                start_c    = !mb_sel;
                req_c.addr = commit_addr(MB_BASE, cur_slot);
                req_c.data = 32'h1;
            end
            default: begin
                start_c = 1'b0;
            end
        endcase
    end

    // Burst sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            last_q     <= 1'b0;
            res_ready  <= 1'b0;
            cur_slot   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            stall_cnt  <= '0;
            commit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    res_ready <= 1'b0;
                    if (enable && res_valid) begin
                        state <= WAIT_SLOT;
                        busy  <= 1'b1;
                    end
                end
                WAIT_SLOT: begin
                    // Only the in-order slot is ever considered.
                    if (!slot_busy_c) begin
                        state     <= DATA;
                        idx       <= '0;
                        res_ready <= 1'b1;
                    end else if (stall_cnt != {STALL_W{1'b1}}) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                DATA: begin
                    if (hs_c) begin
                        res_ready <= 1'b0;
                        last_q    <= res_last;
                    end
                    if (done_c) begin
                        if (idx == LAST_IDX) begin
                            if (last_q) begin
                                state <= COMMIT;
                            end else begin
                                overrun   <= 1'b1;
                                state     <= DRAIN;
                                res_ready <= 1'b1;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                            if (last_q) begin
                                state <= PAD;
                            end else begin
                                res_ready <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    if (done_c) begin
                        if (idx == LAST_IDX) begin
                            state <= COMMIT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Excess words are swallowed; the slot keeps the first 16.
                    if (hs_c && res_last) begin
                        res_ready <= 1'b0;
                        state     <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (done_c) begin
                        cur_slot   <= ~cur_slot;
                        commit_cnt <= commit_cnt + 16'd1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/boreal_ai_mbox_writer.md
Name: boreal_ai_mbox_writer

Overview:
- Producer-side sequencer for the AI mailbox.
- Accepts 16-word inference-result bursts from the AI accelerator stream and writes each burst into a mailbox slot over MMIO: 16 data words, then a single "valid" commit write.
- Slots are used strictly ping-pong (0,1,0,1,...), so the Decision-VM always consumes results in production order.
- Sits between the accelerator output stream and the mailbox MMIO slave port.

Parameters:
- MB_BASE, 32'h0000_0000, mailbox base address added to every mb_addr.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  when low, no new burst is started; a burst in progress completes
- res_valid  in  1  accelerator result word valid
- res_data  in  32  result word
- res_last  in  1  final word of burst
- res_ready  out  1  word accepted when res_valid && res_ready
- mb_sel  out  1  MMIO select
- mb_wr  out  1  MMIO write strobe (always equals mb_sel)
- mb_addr  out  32  MMIO address
- mb_wdata  out  32  MMIO write data
- mb_ack  in  1  MMIO completion
- slot0_valid  in  1  mailbox slot 0 occupied (vm_slot0_valid)
- slot1_valid  in  1  mailbox slot 1 occupied
- cur_slot  out  1  slot the next or current burst targets
- busy  out  1  state != IDLE
- overrun  out  1  sticky: a burst exceeded 16 words; cleared only by reset
- stall_cnt  out  STALL_W  saturating count of cycles spent in WAIT_SLOT
- commit_cnt  out  16  wrapping count of committed slots

Behaviour:
- Reset values: all outputs 0, state IDLE, cur_slot 0, word index 0.
- Reset asserted mid-burst aborts immediately. No commit is issued, so a partially written slot is never marked valid.
- Addressing:
  - Data word i of slot s goes to MB_BASE + (s ? 8'h80 : 8'h40) + 4*i.
  - Commit goes to MB_BASE + (s ? 8'h04 : 8'h00), wdata = 32'h1.
- MMIO rules: mb_sel, mb_addr and mb_wdata are registered and held stable until the cycle mb_ack is sampled high. mb_sel drops the following cycle. There is at most one outstanding access.
- IDLE:
  - Go to WAIT_SLOT when enable && res_valid.
  - res_ready is 0.
- WAIT_SLOT:
  - If the valid input of cur_slot is 0, go to DATA with index 0.
  - Otherwise stay, and stall_cnt increments, saturating at all-ones.
  - The other slot is never used out of order.
- DATA:
  - res_ready = 1 only while mb_sel = 0. A handshake registers the word and asserts mb_sel the next cycle (minimum 2 cycles per word with a single-cycle ack).
  - On mb_ack, index increments.
  - If the accepted word had res_last and index < 15, go to PAD.
  - If index 15 was written with res_last, go to COMMIT.
  - If index 15 was written without res_last, set overrun and go to DRAIN.
- PAD: write 32'h0 to each remaining index up to 15, then go to COMMIT.
- DRAIN:
  - res_ready = 1; words are accepted and discarded until res_last is accepted.
  - Then go to COMMIT, so the slot holds the first 16 words.
- COMMIT:
  - Issue the valid write. On mb_ack, toggle cur_slot, increment commit_cnt, go to IDLE.
  - If the VM acks the slot in the same cycle as the commit, the mailbox takes precedence; the writer does not care.
- A change on enable never interrupts WAIT_SLOT, DATA, PAD, DRAIN or COMMIT.
- res_ready is 0 in IDLE, WAIT_SLOT, PAD and COMMIT.

Decomposition:
- Package boreal_mbox_pkg holds:
  - state encoding localparams;
  - MBOX_SLOT0_VALID=8'h00, MBOX_SLOT1_VALID=8'h04, MBOX_SLOT0_DATA=8'h40, MBOX_SLOT1_DATA=8'h80;
  - MBOX_WORDS=16.
- One natural sub-module, boreal_mmio_wr_port: registered single-outstanding write master (start/addr/data in, sel/addr/wdata out, done on ack).
- FSM and counters stay in the top module.

Test Plan:
- Full burst, both slots free, ack same cycle: words 0x100..0x10F with last on word 15 → slot0 data at 0x40..0x7C, then write 0x00=1; cur_slot becomes 1; commit_cnt=1.
- Short burst of 3 words (last on word 2) into slot1 → 0x80..0x88 data, 0x8C..0xBC written 0, then 0x04=1.
- slot0_valid held high for 50 cycles with a burst pending → no mb_sel, res_ready=0, stall_cnt=50; after release, data writes begin within 1 cycle.
- 20-word burst with last on word 19 → 16 writes, 4 words discarded, overrun=1, commit issued; the next burst goes to the other slot.
- mb_ack delayed 3 cycles on every access → mb_addr/mb_wdata stable throughout; no word lost; order preserved.
- rst_n pulsed during word 7 of a slot0 burst → all outputs 0 asynchronously; no valid write issued; the next burst restarts at slot0 index 0.
